// File: rtl/axil_regfile_if.sv
// AXI-Lite bus bundle (32-bit address, 32-bit data) shared by the UDP bridge
// master and the register bank slave.
interface AXIL_IF;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport Master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport Slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_regfile.sv
// AXI-Lite register bank: NUM_RW control registers followed by NUM_RO status words.
// Optional macro AXIL_REGFILE_WR_PULSE_EN adds a per-register write strobe output wr_pulse.
module axil_regfile #(
    parameter logic [31:0]          BASE_ADDR = 32'h0000_0000,
    parameter int                   NUM_RW    = 8,
    parameter int                   NUM_RO    = 4,
    parameter logic [NUM_RW*32-1:0] RW_RESET  = '0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    AXIL_IF.Slave                                        axil_if,
    output logic [NUM_RW*32-1:0]                         ctrl_out,
    input  logic [((NUM_RO == 0) ? 32 : NUM_RO*32)-1:0]  status_in
`ifdef AXIL_REGFILE_WR_PULSE_EN
    ,
    output logic [NUM_RW-1:0]                            wr_pulse
`endif
);

    localparam int          RW_IW   = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
    localparam int          RO_IW   = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
    localparam logic [31:0] NUM_ALL = 32'(NUM_RW + NUM_RO);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {HIT_RW, HIT_RO, HIT_MISS} hit_e;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_RESP} r_state_e;

    function automatic hit_e decode(input logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr - BASE_ADDR) >> 2;
        if (addr < BASE_ADDR || idx >= NUM_ALL) return HIT_MISS;
        if (idx < 32'(NUM_RW)) return HIT_RW;
        return HIT_RO;
    endfunction

    function automatic logic [RW_IW-1:0] rw_index(input logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr - BASE_ADDR) >> 2;
        return idx[RW_IW-1:0];
    endfunction

    function automatic logic [RO_IW-1:0] ro_index(input logic [31:0] addr);
        logic [31:0] idx;
        idx = ((addr - BASE_ADDR) >> 2) - 32'(NUM_RW);
        return idx[RO_IW-1:0];
    endfunction

    logic [31:0] ctrl_q [NUM_RW];

    logic        unused_prot;
    assign unused_prot = ^{axil_if.awprot, axil_if.arprot};

    genvar gi;
    for (gi = 0; gi < NUM_RW; gi++) begin : g_ctrl_out
        assign ctrl_out[32*gi +: 32] = ctrl_q[gi];
    end

    // ---- write channel: AW/W collection, commit, response ----
    w_state_e    w_state, w_state_nx;
    logic        aw_got, aw_got_nx, w_got, w_got_nx;
    logic        awready_nx, wready_nx, bvalid_nx;
    logic [1:0]  bresp_nx;
    logic        commit_we;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs;

    assign aw_hs = axil_if.awvalid & axil_if.awready;
    assign w_hs  = axil_if.wvalid  & axil_if.wready;

    always_comb begin
        w_state_nx = w_state;
        aw_got_nx  = aw_got;
        w_got_nx   = w_got;
        awready_nx = axil_if.awready;
        wready_nx  = axil_if.wready;
        bvalid_nx  = axil_if.bvalid;
        bresp_nx   = axil_if.bresp;
        commit_we  = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_got_nx  = aw_got | aw_hs;
                w_got_nx   = w_got | w_hs;
                awready_nx = ~aw_got_nx;
                wready_nx  = ~w_got_nx;
                if (aw_got_nx && w_got_nx) w_state_nx = W_COMMIT;
            end
            W_COMMIT: begin
                bvalid_nx  = 1'b1;
                w_state_nx = W_RESP;
                case (decode(awaddr_q))
                    HIT_RW: begin
                        bresp_nx  = RESP_OKAY;
                        commit_we = 1'b1;
                    end
                    HIT_RO:  bresp_nx = RESP_SLVERR;
                    default: bresp_nx = RESP_DECERR;
                endcase
            end
            W_RESP: begin
                if (axil_if.bready) begin
                    bvalid_nx  = 1'b0;
                    awready_nx = 1'b1;
                    wready_nx  = 1'b1;
                    aw_got_nx  = 1'b0;
                    w_got_nx   = 1'b0;
                    w_state_nx = W_IDLE;
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state         <= W_IDLE;
            aw_got          <= 1'b0;
            w_got           <= 1'b0;
            axil_if.awready <= 1'b0;
            axil_if.wready  <= 1'b0;
            axil_if.bvalid  <= 1'b0;
            axil_if.bresp   <= 2'b00;
        end else begin
            w_state         <= w_state_nx;
            aw_got          <= aw_got_nx;
            w_got           <= w_got_nx;
            axil_if.awready <= awready_nx;
            axil_if.wready  <= wready_nx;
            axil_if.bvalid  <= bvalid_nx;
            axil_if.bresp   <= bresp_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) awaddr_q <= axil_if.awaddr;
        if (w_hs) begin
            wdata_q <= axil_if.wdata;
            wstrb_q <= axil_if.wstrb;
        end
    end

    // ---- register update: lands the cycle after commit ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RW; i++) ctrl_q[i] <= RW_RESET[32*i +: 32];
`ifdef AXIL_REGFILE_WR_PULSE_EN
            wr_pulse <= '0;
`endif
        end else begin
`ifdef AXIL_REGFILE_WR_PULSE_EN
            wr_pulse <= '0;
            if (commit_we) wr_pulse[rw_index(awaddr_q)] <= 1'b1;
`endif
            if (commit_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) ctrl_q[rw_index(awaddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ---- read channel: AR decode, held response ----
    r_state_e    r_state, r_state_nx;
    logic        arready_nx, rvalid_nx;
    logic [1:0]  rresp_nx;
    logic [31:0] rdata_nx;
    logic        ar_hs;

    assign ar_hs = axil_if.arvalid & axil_if.arready;

    always_comb begin
        r_state_nx = r_state;
        arready_nx = axil_if.arready;
        rvalid_nx  = axil_if.rvalid;
        rresp_nx   = axil_if.rresp;
        rdata_nx   = axil_if.rdata;
        case (r_state)
            R_IDLE: begin
                arready_nx = 1'b1;
                if (ar_hs) begin
                    rvalid_nx  = 1'b1;
                    arready_nx = 1'b0;
                    r_state_nx = R_RESP;
                    case (decode(axil_if.araddr))
                        HIT_RW: begin
                            rdata_nx = ctrl_q[rw_index(axil_if.araddr)];
                            rresp_nx = RESP_OKAY;
                        end
                        HIT_RO: begin
                            rdata_nx = status_in[32*ro_index(axil_if.araddr) +: 32];
                            rresp_nx = RESP_OKAY;
                        end
                        default: begin
                            rdata_nx = 32'hDEAD_BEEF;
                            rresp_nx = RESP_DECERR;
                        end
                    endcase
                end
            end
            R_RESP: begin
                if (axil_if.rready) begin
                    rvalid_nx  = 1'b0;
                    arready_nx = 1'b1;
                    r_state_nx = R_IDLE;
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= R_IDLE;
            axil_if.arready <= 1'b0;
            axil_if.rvalid  <= 1'b0;
            axil_if.rresp   <= 2'b00;
            axil_if.rdata   <= 32'h0;
        end else begin
            r_state         <= r_state_nx;
            axil_if.arready <= arready_nx;
            axil_if.rvalid  <= rvalid_nx;
            axil_if.rresp   <= rresp_nx;
            axil_if.rdata   <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_axil_regfile.sv
// Scoreboard bench for axil_regfile: expected responses are queued when a transaction
// is issued and popped when the DUT responds.
module tb_axil_regfile;
    localparam logic [31:0]  BASE = 32'h0000_1000;
    localparam logic [255:0] RST  = 256'h1234_5678;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] ctrl_out;
    logic [127:0] status_in;
    AXIL_IF axil();
`ifdef AXIL_REGFILE_WR_PULSE_EN
    logic [7:0]   wr_pulse;
    logic [7:0]   pulse_acc = '0;
    int           pulse_cnt = 0;
`endif

    axil_regfile #(.BASE_ADDR(BASE), .NUM_RW(8), .NUM_RO(4), .RW_RESET(RST)) dut (
        .clk(clk),
        .reset(reset),
        .axil_if(axil),
        .ctrl_out(ctrl_out),
        .status_in(status_in)
`ifdef AXIL_REGFILE_WR_PULSE_EN
        ,
        .wr_pulse(wr_pulse)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model [8];
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];

    task automatic step();
        @(posedge clk);
        #1;
`ifdef AXIL_REGFILE_WR_PULSE_EN
        if (wr_pulse != 8'h0) begin
            pulse_acc |= wr_pulse;
            pulse_cnt++;
        end
`endif
    endtask

    task automatic model_reset();
        logic [255:0] r;
        r = RST;
        for (int i = 0; i < 8; i++) model[i] = r[32*i +: 32];
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] idx;
        idx = (addr - BASE) >> 2;
        if (addr >= BASE && idx < 8) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            exp_b_q.push_back(2'b00);
        end else if (addr >= BASE && idx < 12) exp_b_q.push_back(2'b10);
        else exp_b_q.push_back(2'b11);
    endtask

    task automatic model_read(input logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr - BASE) >> 2;
        if (addr >= BASE && idx < 8) exp_r_q.push_back({2'b00, model[idx]});
        else if (addr >= BASE && idx < 12) exp_r_q.push_back({2'b00, status_in[32*(idx-8) +: 32]});
        else exp_r_q.push_back({2'b11, 32'hDEAD_BEEF});
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, output logic [1:0] resp, output int lat,
                             output logic ok, output logic [255:0] ctrl_at_b);
        int   aw_start, w_start, c;
        logic aw_done, w_done, aw_fire, w_fire;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 1'b0; w_done = 1'b0; c = 0; ok = 1'b1;
        axil.awaddr = addr; axil.wdata = data; axil.wstrb = strb;
        while (!(aw_done && w_done)) begin
            axil.awvalid = !aw_done && (c >= aw_start);
            axil.wvalid  = !w_done && (c >= w_start);
            aw_fire = axil.awvalid && axil.awready;
            w_fire  = axil.wvalid && axil.wready;
            step();
            c++;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire) w_done = 1'b1;
            if (c > 50) begin ok = 1'b0; break; end
        end
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        lat = 1;
        while (!axil.bvalid && lat < 20) begin step(); lat++; end
        if (!axil.bvalid) ok = 1'b0;
        resp = axil.bresp;
        ctrl_at_b = ctrl_out;
        axil.bready = 1'b1;
        step();
        axil.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] data,
                            output logic [1:0] resp, output int lat, output logic ok, output logic stable);
        int   c;
        logic fired;
        c = 0; fired = 1'b0; ok = 1'b1;
        axil.araddr = addr;
        while (!fired) begin
            axil.arvalid = 1'b1;
            fired = axil.arready;
            step();
            c++;
            if (c > 50) begin ok = 1'b0; break; end
        end
        axil.arvalid = 1'b0;
        lat = 1;
        while (!axil.rvalid && lat < 20) begin step(); lat++; end
        if (!axil.rvalid) ok = 1'b0;
        data = axil.rdata; resp = axil.rresp;
        stable = (axil.arready === 1'b0);
        repeat (hold) begin
            step();
            if (!axil.rvalid || axil.rdata !== data || axil.rresp !== resp || axil.arready !== 1'b0) stable = 1'b0;
        end
        axil.rready = 1'b1;
        step();
        axil.rready = 1'b0;
    endtask

    // Issues a write through the scoreboard and checks response, latency and register image.
    task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead);
        logic [1:0] resp, exp; logic ok; int lat; logic [255:0] cab;
        model_write(addr, data, strb);
        axi_write(addr, data, strb, w_lead, resp, lat, ok, cab);
        exp = exp_b_q.pop_front();
        n_checks++;
        if (!ok || resp !== exp || lat != 2) $display("FAIL %s bresp/lat: got %b/%0d ok=%0d, want %b/2", name, resp, lat, ok, exp);
        else n_pass++;
        n_checks++;
        if (cab !== model_flat() || ctrl_out !== model_flat()) $display("FAIL %s ctrl_out: got %h, want %h", name, ctrl_out, model_flat());
        else n_pass++;
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input int hold);
        logic [31:0] data; logic [1:0] resp; logic ok, stable; int lat; logic [33:0] exp;
        model_read(addr);
        axi_read(addr, hold, data, resp, lat, ok, stable);
        exp = exp_r_q.pop_front();
        n_checks++;
        if (!ok || {resp, data} !== exp || lat != 1 || !stable)
            $display("FAIL %s read: got resp=%b data=%h lat=%0d stable=%0d, want resp=%b data=%h lat=1", name, resp, data, lat, stable, exp[33:32], exp[31:0]);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        status_in = '0;
        axil.awvalid = 0; axil.wvalid = 0; axil.bready = 0; axil.arvalid = 0; axil.rready = 0;
        axil.awaddr = 0; axil.wdata = 0; axil.wstrb = 0; axil.araddr = 0; axil.awprot = 0; axil.arprot = 0;
        model_reset();
        repeat (3) step();
        n_checks++;
        if ({axil.awready, axil.wready, axil.bvalid, axil.bresp, axil.arready, axil.rvalid, axil.rresp, axil.rdata} !== 41'h0)
            $display("FAIL reset_outputs: got aw=%b w=%b bv=%b br=%b ar=%b rv=%b rr=%b rd=%h, want all 0",
                     axil.awready, axil.wready, axil.bvalid, axil.bresp, axil.arready, axil.rvalid, axil.rresp, axil.rdata);
        else n_pass++;
        n_checks++;
        if (ctrl_out !== RST) $display("FAIL reset_ctrl: got %h, want %h", ctrl_out, RST);
        else n_pass++;
        reset = 1'b1;
        step(); step();
        n_checks++;
        if ({axil.awready, axil.wready, axil.arready} !== 3'b111)
            $display("FAIL idle_readys: got %b, want 111", {axil.awready, axil.wready, axil.arready});
        else n_pass++;
        do_read("reset_read_reg0", BASE, 0);
    endtask

    task automatic test_write_w_first();
        do_write("w_first_reg1", BASE + 4, 32'hCAFE_F00D, 4'hF, 3);
        do_read("w_first_readback", BASE + 4, 0);
    endtask

    task automatic test_strobe();
        do_write("strobe_reg1", BASE + 4, 32'hFFFF_FFFF, 4'b0101, 0);
        n_checks++;
        if (ctrl_out[63:32] !== 32'hCAFF_F0FF) $display("FAIL strobe_value: got %h, want CAFFF0FF", ctrl_out[63:32]);
        else n_pass++;
        do_write("strobe_zero_reg2", BASE + 8, 32'hFFFF_FFFF, 4'b0000, -1);
    endtask

    task automatic test_ro();
        status_in = {32'h0BAD_F00D, 32'h1357_9BDF, 32'h0246_8ACE, 32'hA5A5_0001};
        do_write("ro_write", BASE + 32, 32'h1111_2222, 4'hF, 0);
        do_read("ro_read_first", BASE + 32, 0);
        do_read("ro_read_last", BASE + 44, 0);
    endtask

    task automatic test_miss();
        do_read("miss_idx12_hold", BASE + 48, 5);
        do_read("miss_below_base", BASE - 4, 0);
        do_write("miss_write", BASE + 48, 32'h5555_5555, 4'hF, -2);
        do_read("addr_low_bits_ignored", BASE + 5, 2);
    endtask

    task automatic test_back_to_back();
        do_write("b2b_reg7", BASE + 28, 32'h89AB_CDEF, 4'hF, 0);
        do_write("b2b_reg6_aw_first", BASE + 24, 32'h0F0F_0F0F, 4'hF, -2);
        do_write("b2b_reg6_top_byte", BASE + 24, 32'h1122_3344, 4'b1000, 1);
        for (int i = 0; i < 8; i++) do_read($sformatf("b2b_read_reg%0d", i), BASE + 32'(4*i), i % 2);
    endtask

    task automatic test_concurrent();
        logic [31:0] rd; logic [1:0] rr, br; logic [33:0] exp_r; logic [1:0] exp_b;
        model_read(BASE + 16);
        model_write(BASE + 16, 32'h5555_AAAA, 4'hF);
        axil.awaddr = BASE + 16; axil.wdata = 32'h5555_AAAA; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        step();
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        axil.araddr = BASE + 16; axil.arvalid = 1'b1;
        n_checks++;
        if (axil.arready !== 1'b1 || axil.bvalid !== 1'b0) $display("FAIL conc_setup: arready=%b bvalid=%b, want 1/0", axil.arready, axil.bvalid);
        else n_pass++;
        step();
        axil.arvalid = 1'b0;
        rd = axil.rdata; rr = axil.rresp; br = axil.bresp;
        exp_r = exp_r_q.pop_front();
        exp_b = exp_b_q.pop_front();
        n_checks++;
        if (axil.rvalid !== 1'b1 || {rr, rd} !== exp_r) $display("FAIL conc_pre_write_read: rvalid=%b got %b/%h, want %b/%h", axil.rvalid, rr, rd, exp_r[33:32], exp_r[31:0]);
        else n_pass++;
        n_checks++;
        if (axil.bvalid !== 1'b1 || br !== exp_b || ctrl_out !== model_flat()) $display("FAIL conc_write: bvalid=%b bresp=%b ctrl=%h, want 1/%b/%h", axil.bvalid, br, ctrl_out, exp_b, model_flat());
        else n_pass++;
        axil.rready = 1'b1; axil.bready = 1'b1;
        step();
        axil.rready = 1'b0; axil.bready = 1'b0;
        do_read("conc_readback", BASE + 16, 0);
    endtask

    task automatic test_reset_mid();
        int n;
        axil.awaddr = BASE + 20; axil.wdata = 32'h7777_7777; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        step();
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        n = 0;
        while (!axil.bvalid && n < 20) begin step(); n++; end
        step(); step();
        n_checks++;
        if (axil.bvalid !== 1'b1 || ctrl_out[191:160] !== 32'h7777_7777) $display("FAIL mid_bvalid_held: bvalid=%b reg5=%h, want 1/77777777", axil.bvalid, ctrl_out[191:160]);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (axil.bvalid !== 1'b0 || ctrl_out !== RST) $display("FAIL mid_async_reset: bvalid=%b ctrl=%h, want 0/%h", axil.bvalid, ctrl_out, RST);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) step();
        n_checks++;
        if (axil.bvalid !== 1'b0 || axil.rvalid !== 1'b0) $display("FAIL mid_no_stale_resp: bvalid=%b rvalid=%b, want 0/0", axil.bvalid, axil.rvalid);
        else n_pass++;
        do_write("mid_after_reset", BASE + 20, 32'h0A0B_0C0D, 4'hF, 0);
    endtask

`ifdef AXIL_REGFILE_WR_PULSE_EN
    task automatic test_pulse();
        pulse_acc = '0; pulse_cnt = 0;
        do_write("pulse_reg3", BASE + 12, 32'h3333_3333, 4'hF, 0);
        n_checks++;
        if (pulse_acc !== 8'b0000_1000 || pulse_cnt != 1) $display("FAIL pulse_okay: got %b x%0d, want 00001000 x1", pulse_acc, pulse_cnt);
        else n_pass++;
        pulse_acc = '0; pulse_cnt = 0;
        do_write("pulse_slverr", BASE + 32, 32'h3333_3333, 4'hF, 0);
        n_checks++;
        if (pulse_acc !== 8'h00 || pulse_cnt != 0) $display("FAIL pulse_slverr: got %b x%0d, want 0 x0", pulse_acc, pulse_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_write_w_first();
        test_strobe();
        test_ro();
        test_miss();
        test_back_to_back();
        test_concurrent();
`ifdef AXIL_REGFILE_WR_PULSE_EN
        test_pulse();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
